// File: rtl/neural_sim_sequencer_if.sv
// Memory-read and sample-stream bundle between the playback sequencer and its neighbours.
// The sequencer is the master: it drives the read address/strobe and the output sample.
interface neural_sim_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 12
);
  logic        [ADDR_W-1:0] MEM_ADDR;
  logic                     MEM_RD;
  logic signed [DATA_W-1:0] MEM_DATA;
  logic signed [DATA_W-1:0] DOUT;
  logic                     DOUT_VALID;
  logic                     DOUT_READY;

  modport master (output MEM_ADDR, MEM_RD, DOUT, DOUT_VALID,
                  input  MEM_DATA, DOUT_READY);
  modport slave  (input  MEM_ADDR, MEM_RD, DOUT, DOUT_VALID,
                  output MEM_DATA, DOUT_READY);
endinterface

// File: rtl/neural_sim_sequencer.sv
// Sample-memory playback sequencer: divides CLK_ADC to the sample rate and streams N passes.
// Optional NEURAL_SEQ_STALL_EN holds a read tick while the output is blocked (no drops).
module neural_sim_sequencer #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 12,
  parameter int DEPTH   = 40000,
  parameter int CLK_DIV = 5,
  parameter int LOOP_W  = 8
) (
  input  logic              CLK_ADC,
  input  logic              nRST,
  input  logic              START,
  input  logic              STOP,
  input  logic              PAUSE,
  input  logic [LOOP_W-1:0] LOOPS,
  neural_sim_sequencer_if.master bus,
  output logic              BUSY,
  output logic              DONE,
  output logic [LOOP_W-1:0] PASS_CNT,
  output logic              OVERRUN
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  state_t                   state_q;
  logic        [DIV_W-1:0]  div_q;
  logic        [ADDR_W-1:0] addr_q;
  logic        [LOOP_W-1:0] pass_q, loops_q;
  logic                     rd_q, vld_q, done_q, ovr_q;
  logic signed [DATA_W-1:0] dout_q;

  logic              div_end, hold, tick, advance, wrap, capture;
  logic [LOOP_W-1:0] pass_d;

  assign div_end = (state_q == S_RUN) && (div_q == DIV_W'(CLK_DIV - 1));
`ifdef NEURAL_SEQ_STALL_EN
  assign hold = vld_q && !bus.DOUT_READY;
`else
  assign hold = 1'b0;
`endif
  assign tick    = div_end && !PAUSE && !hold;
  // The divider only freezes at its terminal count when stalled; PAUSE freezes it anywhere.
  assign advance = !PAUSE && !(div_end && hold);
  assign wrap    = (addr_q == ADDR_W'(DEPTH - 1));
  assign pass_d  = pass_q + LOOP_W'(1);
  assign capture = rd_q && !STOP;

  always_ff @(posedge CLK_ADC or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      addr_q  <= '0;
      pass_q  <= '0;
      loops_q <= '0;
      rd_q    <= 1'b0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      done_q <= 1'b0;
      // A read issued alongside STOP is dropped with the rest of the run.
      rd_q   <= tick && !STOP;
      case (state_q)
        S_IDLE: if (START && !STOP) begin
          state_q <= S_RUN;
          div_q   <= '0;
          addr_q  <= '0;
          pass_q  <= '0;
          loops_q <= LOOPS;
          ovr_q   <= 1'b0;
        end
        S_RUN: if (STOP) begin
          state_q <= S_IDLE;
        end else if (advance) begin
          div_q <= div_end ? '0 : div_q + DIV_W'(1);
          if (tick) begin
            if (wrap) begin
              addr_q <= '0;
              pass_q <= pass_d;
              if (loops_q != '0 && pass_d == loops_q) state_q <= S_FINISH;
            end else begin
              addr_q <= addr_q + ADDR_W'(1);
            end
          end
        end
        S_FINISH: begin
          state_q <= S_IDLE;
          done_q  <= !STOP;
        end
        default: state_q <= S_IDLE;
      endcase

      if (STOP) begin
        vld_q <= 1'b0;
      end else if (capture) begin
        dout_q <= bus.MEM_DATA;
        vld_q  <= 1'b1;
`ifndef NEURAL_SEQ_STALL_EN
        if (vld_q && !bus.DOUT_READY) ovr_q <= 1'b1;
`endif
      end else if (vld_q && bus.DOUT_READY) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign bus.MEM_ADDR   = addr_q;
  assign bus.MEM_RD     = tick;
  assign bus.DOUT       = dout_q;
  assign bus.DOUT_VALID = vld_q;
  assign BUSY           = (state_q != S_IDLE);
  assign DONE           = done_q;
  assign PASS_CNT       = pass_q;
  assign OVERRUN        = ovr_q;
endmodule

// File: tb/tb_neural_sim_sequencer.sv
// Directed bench for neural_sim_sequencer with DEPTH=8, CLK_DIV=5 and an 8-entry sample memory.
// Cycle n is the interval after the n-th rising edge following START; checks sit on falling edges.
module tb_neural_sim_sequencer;
  logic       clk, nRST, START, STOP, PAUSE;
  logic [7:0] LOOPS, PASS_CNT;
  logic       BUSY, DONE, OVERRUN;
  int         total, bad, cyc, rdn, dn;
  logic       exp_rd, exp_v;
  logic signed [11:0] mem [8];

  neural_sim_sequencer_if #(.ADDR_W(16), .DATA_W(12)) bus ();

  neural_sim_sequencer #(
    .ADDR_W(16), .DATA_W(12), .DEPTH(8), .CLK_DIV(5), .LOOP_W(8)
  ) dut (
    .CLK_ADC(clk), .nRST(nRST), .START(START), .STOP(STOP), .PAUSE(PAUSE),
    .LOOPS(LOOPS), .bus(bus), .BUSY(BUSY), .DONE(DONE),
    .PASS_CNT(PASS_CNT), .OVERRUN(OVERRUN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1-cycle-latency sample memory
  always @(posedge clk) if (bus.MEM_RD) bus.MEM_DATA <= mem[bus.MEM_ADDR[2:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic adv();
    @(negedge clk);
    cyc++;
  endtask

  task automatic start_run(input logic [7:0] n);
    START = 1'b1;
    LOOPS = n;
    cyc   = 0;
    @(negedge clk);
    START = 1'b0;
    cyc   = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0; cyc = 0;
    for (int i = 0; i < 8; i++) mem[i] = 12'(i * 301 - 900);
    nRST = 1'b0; START = 1'b0; STOP = 1'b0; PAUSE = 1'b0; LOOPS = '0;
    bus.DOUT_READY = 1'b1; bus.MEM_DATA = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_addr", bus.MEM_ADDR, 0);
    chk("rst_rd", bus.MEM_RD, 0);
    chk("rst_vld", bus.DOUT_VALID, 0);
    chk("rst_dout", bus.DOUT, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_pass", PASS_CNT, 0);
    chk("rst_ovr", OVERRUN, 0);
    nRST = 1'b1;
    @(negedge clk);

    // single pass: reads at 5..40, samples 2 cycles later, DONE at 42
    start_run(8'd1);
    while (cyc < 46) begin
      exp_rd = (cyc >= 5 && cyc <= 40 && cyc % 5 == 0);
      chk("t1_rd", bus.MEM_RD, exp_rd);
      if (exp_rd) chk("t1_addr", bus.MEM_ADDR, cyc / 5 - 1);
      exp_v = (cyc >= 7 && cyc <= 42 && (cyc - 2) % 5 == 0);
      chk("t1_vld", bus.DOUT_VALID, exp_v);
      if (exp_v) chk("t1_dout", bus.DOUT, mem[(cyc - 2) / 5 - 1]);
      chk("t1_done", DONE, cyc == 42);
      chk("t1_busy", BUSY, cyc >= 1 && cyc <= 41);
      chk("t1_pass", PASS_CNT, cyc >= 41);
      adv();
    end

    // two passes: 16 reads, one DONE at 82
    rdn = 0; dn = 0;
    start_run(8'd2);
    while (cyc < 90) begin
      if (bus.MEM_RD) begin
        chk("t2_addr", bus.MEM_ADDR, rdn % 8);
        rdn++;
      end
      if (DONE) begin
        dn++;
        chk("t2_donecyc", cyc, 82);
      end
      if (cyc == 50) chk("t2_pass_mid", PASS_CNT, 1);
      adv();
    end
    chk("t2_reads", rdn, 16);
    chk("t2_dones", dn, 1);
    chk("t2_pass", PASS_CNT, 2);

    // downstream blocked across two ticks
    bus.DOUT_READY = 1'b0;
    start_run(8'd0);
    while (cyc < 18) begin
      if (cyc == 13) bus.DOUT_READY = 1'b1;
      if (cyc == 16) STOP = 1'b1;
      if (cyc == 17) STOP = 1'b0;
      #1;
`ifdef NEURAL_SEQ_STALL_EN
      if (cyc == 10 || cyc == 12) chk("t3_hold_rd", bus.MEM_RD, 0);
      if (cyc == 12) begin
        chk("t3_old_dout", bus.DOUT, mem[0]);
        chk("t3_old_vld", bus.DOUT_VALID, 1);
      end
      if (cyc == 13) begin
        chk("t3_rel_rd", bus.MEM_RD, 1);
        chk("t3_rel_addr", bus.MEM_ADDR, 1);
      end
      if (cyc == 15) begin
        chk("t3_next_vld", bus.DOUT_VALID, 1);
        chk("t3_next_dout", bus.DOUT, mem[1]);
        chk("t3_ovr", OVERRUN, 0);
      end
`else
      if (cyc == 10) chk("t3_rd", bus.MEM_RD, 1);
      if (cyc == 13) begin
        chk("t3_ovr", OVERRUN, 1);
        chk("t3_vld", bus.DOUT_VALID, 1);
        chk("t3_dout", bus.DOUT, mem[1]);
      end
`endif
      if (cyc == 17) begin
        chk("t3_stop_busy", BUSY, 0);
        chk("t3_stop_vld", bus.DOUT_VALID, 0);
      end
      adv();
    end

    // PAUSE for 7 cycles stretches the interval to 12; STOP after the next read
    start_run(8'd0);
    while (cyc < 30) begin
      if (cyc == 11) PAUSE = 1'b1;
      if (cyc == 18) PAUSE = 1'b0;
      if (cyc == 23) STOP = 1'b1;
      if (cyc == 24) STOP = 1'b0;
      #1;
      if (cyc == 1) chk("t4_ovr_clr", OVERRUN, 0);
      chk("t4_rd", bus.MEM_RD, cyc == 5 || cyc == 10 || cyc == 22);
      chk("t4_done", DONE, 0);
      if (cyc == 12) begin
        chk("t4_pause_vld", bus.DOUT_VALID, 1);
        chk("t4_pause_dout", bus.DOUT, mem[1]);
      end
      if (cyc == 22) chk("t4_addr", bus.MEM_ADDR, 2);
      if (cyc == 24 || cyc == 25) begin
        chk("t4_stop_vld", bus.DOUT_VALID, 0);
        chk("t4_stop_busy", BUSY, 0);
      end
      adv();
    end

    // START with STOP in IDLE is ignored
    START = 1'b1; STOP = 1'b1; cyc = 0;
    adv();
    START = 1'b0; STOP = 1'b0;
    while (cyc < 9) begin
      chk("t5_busy", BUSY, 0);
      chk("t5_rd", bus.MEM_RD, 0);
      adv();
    end

    // asynchronous reset mid-run, then restart from address 0
    start_run(8'd0);
    while (cyc < 12) adv();
    chk("t6_pre_addr", bus.MEM_ADDR, 2);
    chk("t6_pre_vld", bus.DOUT_VALID, 1);
    nRST = 1'b0;
    #1;
    chk("t6_addr", bus.MEM_ADDR, 0);
    chk("t6_vld", bus.DOUT_VALID, 0);
    chk("t6_dout", bus.DOUT, 0);
    chk("t6_busy", BUSY, 0);
    chk("t6_pass", PASS_CNT, 0);
    @(negedge clk);
    nRST = 1'b1;
    @(negedge clk);
    start_run(8'd0);
    while (cyc < 8) begin
      if (cyc == 5) begin
        chk("t6_re_rd", bus.MEM_RD, 1);
        chk("t6_re_addr", bus.MEM_ADDR, 0);
        chk("t6_re_pass", PASS_CNT, 0);
      end
      adv();
    end
    STOP = 1'b1;
    adv();
    STOP = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/neural_sim_sequencer.md
# neural_sim_sequencer

Playback sequencer for the neural test-data sample memory in the FPGA simulation path. It divides the ADC clock down to the sample rate and issues read addresses to a 1-cycle-latency sample memory. It runs a programmable number of passes over the data set and presents each sample on a valid/ready output toward the spike-detection datapath. It also handles start/stop/pause control and end-of-run signalling.

## Interface
Parameters:
- ADDR_W, 16: memory address width; DEPTH ≤ 2^ADDR_W.
- DATA_W, 12: signed sample width.
- DEPTH, 40000: samples per pass; addresses 0..DEPTH-1.
- CLK_DIV, 5: CLK_ADC cycles per sample; must be ≥ 3.
- LOOP_W, 8: width of the pass-count fields.

Ports:
- CLK_ADC, input, 1: the single clock.
- nRST, input, 1: reset. Asynchronous, active-low.
- START, input, 1: start pulse; accepted in IDLE only.
- STOP, input, 1: abort pulse; has priority over START.
- PAUSE, input, 1: level input; freezes sample timing while high.
- LOOPS, input, LOOP_W: number of passes, latched at START; 0 = infinite.
- MEM_ADDR, output, ADDR_W: read address.
- MEM_RD, output, 1: read strobe.
- MEM_DATA, input, DATA_W (signed): read data, valid the cycle after MEM_RD.
- DOUT, output, DATA_W (signed): sample output.
- DOUT_VALID, output, 1: DOUT holds a sample.
- DOUT_READY, input, 1: downstream accepts the sample.
- BUSY, output, 1: high in RUN or FINISH.
- DONE, output, 1: one-cycle end-of-run pulse.
- PASS_CNT, output, LOOP_W: number of completed passes.
- OVERRUN, output, 1: sticky flag for a dropped sample.

## Operation
- States:
  - IDLE.
  - RUN: divider counts 0..CLK_DIV-1.
  - FINISH: final read in flight.
- IDLE→RUN on START (and !STOP). This resets the divider, MEM_ADDR and PASS_CNT to 0, clears OVERRUN and latches LOOPS.
- Tick: RUN, div_cnt==CLK_DIV-1, PAUSE low. MEM_RD is high exactly in tick cycles, driving the current MEM_ADDR. The address advances at the end of the tick cycle.
- Wrap: on the tick that reads DEPTH-1, MEM_ADDR returns to 0 and PASS_CNT increments.
- End of run: if the incremented PASS_CNT equals a nonzero latched LOOPS, the state goes RUN→FINISH. FINISH lasts one cycle, then the state goes to IDLE with DONE=1 for that one cycle.
- Infinite mode (LOOPS=0): PASS_CNT wraps modulo 2^LOOP_W. The run ends only on STOP.
- Capture: in the cycle after MEM_RD, MEM_DATA is registered into DOUT and DOUT_VALID is set.
- Transfer: occurs on an edge with DOUT_VALID && DOUT_READY. Valid clears unless a capture happens on the same edge; in that case valid stays 1 with the new data.
- Overrun: a capture while DOUT_VALID && !DOUT_READY overwrites DOUT and sets OVERRUN. OVERRUN stays set until the next START.
- PAUSE: div_cnt holds and MEM_RD is suppressed. An in-flight read still captures.
- STOP in RUN/FINISH:
  - next state IDLE, DOUT_VALID=0;
  - any in-flight capture is discarded;
  - no DONE.
- STOP in IDLE: no effect except DOUT_VALID=0.
- START is ignored outside IDLE.
- After DONE, a pending last sample remains valid in IDLE until it is accepted.

## Timing
- Reset values: MEM_ADDR=0, MEM_RD=0, DOUT=0, DOUT_VALID=0, BUSY=0, DONE=0, PASS_CNT=0, OVERRUN=0, state IDLE.
- Reset mid-run applies these values asynchronously. Restart requires a new START.
- START sampled in cycle 0 → RUN from cycle 1 → first MEM_RD in cycle CLK_DIV → DOUT_VALID from cycle CLK_DIV+2.
- Subsequent reads follow every CLK_DIV cycles, plus any PAUSE cycles.
- Read issued in cycle k → DOUT valid in cycle k+2.
- Final read in cycle k: FINISH in k+1; DONE, BUSY=0 and last DOUT_VALID in k+2.
- PAUSE high for n cycles stretches the current sample interval by exactly n.

## Configuration
- NEURAL_SEQ_STALL_EN defined:
  - a tick whose cycle has DOUT_VALID && !DOUT_READY is held: div_cnt stays at CLK_DIV-1 and MEM_RD stays low until that condition clears;
  - no sample is ever dropped and OVERRUN stays 0.
- Undefined: real-time behaviour. Ticks are never delayed, and the overrun/overwrite rule above applies.

## Test plan
- CLK_DIV=5, DEPTH=8, LOOPS=1, READY=1, START at cycle 0 → MEM_RD in cycles 5,10,…,40 with addresses 0..7. DOUT matches memory 2 cycles later. DONE only in cycle 42, BUSY low from 42, PASS_CNT=1.
- DEPTH=4, LOOPS=3 → 12 reads with addresses 0,1,2,3 repeated. PASS_CNT steps 1,2,3. Exactly one DONE.
- READY=0 across two ticks, macro off → OVERRUN=1 and DOUT equals the newer sample. Macro on → MEM_RD delayed until READY, all samples delivered in order, OVERRUN=0.
- PAUSE high 7 cycles between reads → the read interval is 12 cycles. A read in flight when PAUSE rises still captures.
- STOP in the cycle after a MEM_RD → no capture, DOUT_VALID=0 and BUSY=0 next cycle, no DONE. START+STOP together in IDLE → stays IDLE.
- nRST low mid-run → all outputs at reset values immediately. After release, START restarts at address 0 with PASS_CNT=0.
